// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core LSU and the
// GEMM accelerator DMA port. One grant per cycle, round-robin on ties, optional
// accelerator burst lock bounded by MAX_BURST, and 1-cycle read-data routing.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_mask,
  output logic              core_gnt,
  output logic [31:0]       core_rdata,
  output logic              core_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  input  logic [3:0]        acc_mask,
  input  logic              acc_lock,
  output logic              acc_gnt,
  output logic [31:0]       acc_rdata,
  output logic              acc_rvalid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {ARB, ACC_BURST} state_t;

  state_t           state_reg, state_next;
  logic             last_acc_reg, last_acc_next;   // 1: most recent grant went to acc
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic             rd_owner_acc_reg;              // 1: outstanding read belongs to acc
  logic             rd_owner_vld_reg;
  logic             gnt_core_raw, gnt_acc_raw;
  logic             rd_issue;

  // State, round-robin pointer and burst counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ARB;
      last_acc_reg  <= 1'b1;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      last_acc_reg  <= last_acc_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Grant decision and next-state logic; a dropped lock falls through to normal arbitration
  always_comb begin
    gnt_core_raw   = 1'b0;
    gnt_acc_raw    = 1'b0;
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    last_acc_next  = last_acc_reg;
    if (state_reg == ACC_BURST && acc_req && acc_lock) begin
      if (burst_cnt_reg < MAX_CNT || !core_req) begin
        gnt_acc_raw    = 1'b1;
        burst_cnt_next = (burst_cnt_reg < MAX_CNT) ? burst_cnt_reg + ONE_CNT : MAX_CNT;
      end else begin
        gnt_core_raw   = 1'b1;
        burst_cnt_next = '0;
        state_next     = ARB;
      end
    end else begin
      state_next     = ARB;
      burst_cnt_next = '0;
      if (core_req && acc_req) begin
        gnt_core_raw = last_acc_reg;
        gnt_acc_raw  = !last_acc_reg;
      end else begin
        gnt_core_raw = core_req;
        gnt_acc_raw  = acc_req;
      end
      if (gnt_acc_raw && acc_lock) begin
        state_next     = ACC_BURST;
        burst_cnt_next = ONE_CNT;
      end
    end
    if (gnt_core_raw) begin
      last_acc_next = 1'b0;
    end else if (gnt_acc_raw) begin
      last_acc_next = 1'b1;
    end
  end

  // Grants are forced low while reset is asserted so the memory bus goes quiet at once
  always_comb begin
    core_gnt  = gnt_core_raw & rst_n;
    acc_gnt   = gnt_acc_raw & rst_n;
    mem_cs    = core_gnt | acc_gnt;
    mem_we    = (core_gnt & core_we) | (acc_gnt & acc_we);
    mem_addr  = core_gnt ? core_addr  : (acc_gnt ? acc_addr  : '0);
    mem_wdata = core_gnt ? core_wdata : (acc_gnt ? acc_wdata : '0);
    rd_issue  = mem_cs & ~mem_we;
  end

  // Byte-lane enables only pass through for a granted write
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_mask[gi] = (core_gnt & core_we & core_mask[gi]) |
                            (acc_gnt & acc_we & acc_mask[gi]);
    end
  endgenerate

  // Remember who owns the read whose data returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_vld_reg <= 1'b0;
      rd_owner_acc_reg <= 1'b0;
    end else begin
      rd_owner_vld_reg <= rd_issue;
      if (rd_issue) begin
        rd_owner_acc_reg <= acc_gnt;
      end
    end
  end

  // Read data is shared; only the owner sees rvalid
  always_comb begin
    core_rdata  = mem_rdata;
    acc_rdata   = mem_rdata;
    core_rvalid = mem_valid & rd_owner_vld_reg & ~rd_owner_acc_reg;
    acc_rvalid  = mem_valid & rd_owner_vld_reg & rd_owner_acc_reg;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized checks of dmem_arbiter against a
// rule-level reference model and a shadow copy of memory.
module tb_dmem_arbiter;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        core_req = 0, core_we = 0, acc_req = 0, acc_we = 0, acc_lock = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, acc_addr = 0, acc_wdata = 0;
  logic [3:0]  core_mask = 0, acc_mask = 0;
  logic        core_gnt, core_rvalid, acc_gnt, acc_rvalid;
  logic [31:0] core_rdata, acc_rdata;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata = 0;
  logic        mem_valid = 0;

  dmem_arbiter #(.ADDR_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mask(core_mask), .core_gnt(core_gnt),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_mask(acc_mask), .acc_lock(acc_lock),
    .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  // Memory: writes on negedge, 1-cycle registered read
  logic [31:0] mem_arr [0:255];
  logic [31:0] shadow  [0:255];

  always @(negedge clk) begin
    if (mem_cs && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    mem_valid <= mem_cs & ~mem_we;
    mem_rdata <= mem_arr[mem_addr[9:2]];
  end

  // Reference model state
  int          total = 0, bad = 0;
  bit          m_last_acc;
  int          m_run;
  bit          exp_rv_core, exp_rv_acc;
  logic [31:0] exp_rd;
  bit          g_core, g_acc;

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_acc  = 1'b1;
    m_run       = 0;
    exp_rv_core = 1'b0;
    exp_rv_acc  = 1'b0;
  endtask

  task automatic clear_reqs();
    core_req = 0; acc_req = 0; acc_lock = 0; core_we = 0; acc_we = 0;
  endtask

  // One cycle: caller has set the request variables; they are applied #1 after posedge
  logic        n_core_req, n_core_we, n_acc_req, n_acc_we, n_acc_lock;
  logic [31:0] n_core_addr, n_core_wdata, n_acc_addr, n_acc_wdata;
  logic [3:0]  n_core_mask, n_acc_mask;

  task automatic step(input string tag);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        e_we;
    int          idx;
    @(posedge clk);
    #1;
    core_req = n_core_req; core_we = n_core_we; core_addr = n_core_addr;
    core_wdata = n_core_wdata; core_mask = n_core_mask;
    acc_req = n_acc_req; acc_we = n_acc_we; acc_addr = n_acc_addr;
    acc_wdata = n_acc_wdata; acc_mask = n_acc_mask; acc_lock = n_acc_lock;
    #2;
    chk(tag, "core_rvalid", {31'b0, core_rvalid}, {31'b0, exp_rv_core});
    chk(tag, "acc_rvalid", {31'b0, acc_rvalid}, {31'b0, exp_rv_acc});
    if (exp_rv_core) chk(tag, "core_rdata", core_rdata, exp_rd);
    if (exp_rv_acc)  chk(tag, "acc_rdata", acc_rdata, exp_rd);
    // Expected grant from the rules: locked run continues unless the core has waited MAX_BURST
    g_core = 0; g_acc = 0;
    if (m_run > 0 && acc_req && acc_lock) begin
      if (m_run >= MAX_BURST && core_req) g_core = 1; else g_acc = 1;
    end else if (core_req && acc_req) begin
      g_core = m_last_acc; g_acc = !m_last_acc;
    end else begin
      g_core = core_req; g_acc = acc_req;
    end
    e_we = 0; e_addr = 0; e_mask = 0; e_wdata = 0;
    if (g_core) begin e_we = core_we; e_addr = core_addr; e_wdata = core_wdata; e_mask = core_we ? core_mask : 4'b0; end
    if (g_acc)  begin e_we = acc_we;  e_addr = acc_addr;  e_wdata = acc_wdata;  e_mask = acc_we ? acc_mask : 4'b0; end
    chk(tag, "core_gnt", {31'b0, core_gnt}, {31'b0, g_core});
    chk(tag, "acc_gnt", {31'b0, acc_gnt}, {31'b0, g_acc});
    chk(tag, "mem_cs", {31'b0, mem_cs}, {31'b0, g_core | g_acc});
    chk(tag, "mem_we", {31'b0, mem_we}, {31'b0, e_we});
    chk(tag, "mem_addr", mem_addr, e_addr);
    chk(tag, "mem_mask", {28'b0, mem_mask}, {28'b0, e_mask});
    if (g_core | g_acc) chk(tag, "mem_wdata", mem_wdata, e_wdata);
    // Advance the model
    if (g_acc && acc_lock) m_run = (m_run + 1 > MAX_BURST) ? MAX_BURST : m_run + 1;
    else m_run = 0;
    if (g_core) m_last_acc = 0;
    else if (g_acc) m_last_acc = 1;
    idx = int'(e_addr[9:2]);
    exp_rv_core = g_core && !e_we;
    exp_rv_acc  = g_acc && !e_we;
    if ((g_core | g_acc) && !e_we) exp_rd = shadow[idx];
    if ((g_core | g_acc) && e_we)
      for (int b = 0; b < 4; b++)
        if (e_mask[b]) shadow[idx][8*b +: 8] = e_wdata[8*b +: 8];
  endtask

  task automatic set_idle();
    n_core_req = 0; n_core_we = 0; n_core_addr = 0; n_core_wdata = 0; n_core_mask = 0;
    n_acc_req = 0; n_acc_we = 0; n_acc_addr = 0; n_acc_wdata = 0; n_acc_mask = 0; n_acc_lock = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, "core_gnt", {31'b0, core_gnt}, 32'd0);
    chk(tag, "acc_gnt", {31'b0, acc_gnt}, 32'd0);
    chk(tag, "core_rvalid", {31'b0, core_rvalid}, 32'd0);
    chk(tag, "acc_rvalid", {31'b0, acc_rvalid}, 32'd0);
    chk(tag, "mem_cs", {31'b0, mem_cs}, 32'd0);
    chk(tag, "mem_we", {31'b0, mem_we}, 32'd0);
    chk(tag, "mem_addr", mem_addr, 32'd0);
    chk(tag, "mem_mask", {28'b0, mem_mask}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    set_idle();
  endtask

  initial begin
    bit p_core, p_acc;
    for (int i = 0; i < 256; i++) begin mem_arr[i] = 32'h0; shadow[i] = 32'h0; end
    model_reset();
    set_idle();

    // Requests present while held in reset must not be granted
    core_req = 1; acc_req = 1; core_addr = 32'h40;
    #3;
    check_all_zero("reset_hold");
    do_reset();

    // Both requesting without lock: C,A,C,A from reset
    n_core_req = 1; n_core_addr = 32'h10; n_acc_req = 1; n_acc_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step("rr");
      chk("rr_seq", "gnt", {30'b0, acc_gnt, core_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Locked burst: core, then 8 acc, then core, then acc again
    n_acc_lock = 1;
    for (int i = 0; i < 11; i++) begin
      step("burst");
      chk("burst_seq", "gnt", {30'b0, acc_gnt, core_gnt}, (i == 0 || i == 9) ? 32'd1 : 32'd2);
    end
    set_idle();
    step("idle");

    // Core read of 0x40 alone, response next cycle
    n_core_req = 1; n_core_addr = 32'h40;
    step("rd40");
    set_idle();
    step("rd40_resp");
    chk("rd40_resp", "core_rvalid_direct", {31'b0, core_rvalid}, 32'd1);

    // Acc masked write then core read back of the low half
    n_acc_req = 1; n_acc_we = 1; n_acc_addr = 32'h100; n_acc_wdata = 32'hAABBCCDD; n_acc_mask = 4'b0011;
    step("wr100");
    set_idle();
    step("wr100_after");
    n_core_req = 1; n_core_addr = 32'h100;
    step("rd100");
    set_idle();
    step("rd100_resp");
    chk("rd100_resp", "core_rdata_direct", core_rdata, 32'h0000CCDD);

    // Back-to-back core read then acc read
    n_core_req = 1; n_core_addr = 32'h100;
    step("b2b_core");
    set_idle();
    n_acc_req = 1; n_acc_addr = 32'h40;
    step("b2b_acc");
    set_idle();
    step("b2b_tail");

    // Read in flight when reset hits: its data must be dropped
    n_core_req = 1; n_core_addr = 32'h100;
    step("pre_reset_rd");
    @(posedge clk); #1;
    clear_reqs();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    do_reset();

    // Randomized traffic, requests held until granted
    p_core = 0; p_acc = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p_core) begin
        n_core_req = ($urandom_range(0, 99) < 60);
        n_core_we = $urandom_range(0, 1);
        n_core_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        n_core_wdata = $urandom;
        n_core_mask = 4'($urandom_range(0, 15));
      end
      if (!p_acc) begin
        n_acc_req = ($urandom_range(0, 99) < 70);
        n_acc_we = $urandom_range(0, 1);
        n_acc_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        n_acc_wdata = $urandom;
        n_acc_mask = 4'($urandom_range(0, 15));
      end
      n_acc_lock = ($urandom_range(0, 99) < 75);
      step("rand");
      p_core = n_core_req && !g_core;
      p_acc  = n_acc_req && !g_acc;
    end
    set_idle();
    step("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
